axis_iic_cmd_packer: RTL and testbench
======================================

// Module: axis_iic_cmd_packer
// PURPOSE
//  Upstream feeder for the AXI-Stream I2C bridge. Accepts byte-wide I2C command packets.
//  Packs each packet into N_BYTES-wide beats, with the I2C header carried in tuser and
//  valid bytes marked in tkeep. This lets narrow sources (UART/CPU byte streams) drive
//  the wide bridge input directly.
// PARAMETERS
//  N_BYTES   32   output beat width in bytes; must match the downstream bridge N_BYTES (>=2)
// PORTS
//  clk            in   1          single clock, all logic on rising edge
//  resetn         in   1          reset, asynchronous assert, active-low
//  s_axis_tdata   in   8          command byte stream
//  s_axis_tvalid  in   1          input byte valid
//  s_axis_tready  out  1          input byte accepted when tvalid&tready
//  s_axis_tlast   in   1          last byte of command packet
//  m_axis_tdata   out  N_BYTES*8  packed payload, byte i in bits [8i+7:8i]
//  m_axis_tkeep   out  N_BYTES    byte-valid mask, contiguous from lane 0
//  m_axis_tuser   out  8          I2C header {addr[6:0], rw}, rw=1 read
//  m_axis_tvalid  out  1          output beat valid
//  m_axis_tready  in   1          downstream ready
//  m_axis_tlast   out  1          final beat of a command
//  err_fmt        out  1          one-cycle pulse: malformed packet dropped
// BEHAVIOUR
//  Packet format:
//   - byte0 = header.
//   - Write (hdr[0]=0): bytes 1..k are payload, k>=0.
//   - Read (hdr[0]=1): byte1 = read length L, 1<=L<=N_BYTES, and byte1 must carry tlast.
//  FSM states: HDR_ST, WR_ST, RDLEN_ST, OUT_ST, DROP_ST.
//   - HDR_ST: accept byte0 and latch it as header.
//       tlast & rw=0            -> OUT_ST, null beat: tkeep=0, tlast=1 (address probe).
//       tlast & rw=1            -> err_fmt pulse, stay HDR_ST, no output.
//       !tlast                  -> WR_ST (rw=0) or RDLEN_ST (rw=1).
//   - WR_ST: each accepted byte goes to lane cnt; set tkeep[cnt]; cnt++.
//       On tlast, or when lane N_BYTES-1 is filled -> OUT_ST; m_axis_tlast = input tlast.
//   - RDLEN_ST: accept byte1.
//       tlast & 1<=L<=N_BYTES   -> OUT_ST, beat tdata[7:0]=L, upper bytes 0, tkeep=1, tlast=1.
//       tlast & (L==0 | L>N_BYTES) -> err_fmt pulse, back to HDR_ST, no output.
//       !tlast                  -> err_fmt pulse, DROP_ST.
//   - DROP_ST: s_axis_tready=1; discard bytes until tlast is accepted, then HDR_ST.
//   - OUT_ST: m_axis_tvalid=1, s_axis_tready=0.
//       On m_axis_tready: clear tdata/tkeep and cnt.
//       Next state is HDR_ST if the beat had tlast, else WR_ST (continuation beat, same tuser).
//  Handshake and timing:
//   - m_axis_* are registered and held stable while tvalid & !tready.
//   - tvalid never drops without a handshake.
//   - s_axis_tready is registered: 1 in HDR_ST/WR_ST/RDLEN_ST/DROP_ST, 0 in OUT_ST and in reset.
//   - Latency: the beat appears the cycle after the completing byte is accepted.
//   - Throughput: 1 byte/clk while packing, plus >=1 cycle bubble per output beat.
//   - Unused data lanes are driven 0.
//   - Write with payload exactly N_BYTES gives one full beat with tlast.
//     Payload N_BYTES+1 gives two beats; the second has tkeep=1 and tlast.
//  Reset: async resetn=0 gives:
//   - state HDR_ST, cnt=0.
//   - m_axis_tvalid/tdata/tkeep/tuser/tlast = 0.
//   - s_axis_tready=0, err_fmt=0.
//   Mid-packet reset discards the partial packet. After release, input resumes at a header byte.
// TESTING (bench with N_BYTES=4)
//  1. Write: 0xA0,0x11,0x22(last) -> one beat: tuser=A0, tdata=0x00002211, tkeep=0011, tlast=1.
//  2. Write: 0xA0 plus 5 payload 01..05 -> beat1 tkeep=1111, tdata=0x04030201, tlast=0;
//     beat2 tkeep=0001, tdata=0x05, tlast=1; both tuser=A0.
//  3. Read: 0xA1,0x03(last) -> one beat: tuser=A1, tdata=0x03, tkeep=0001, tlast=1.
//     Read with L=0 or L=5 -> err_fmt pulse, no beat.
//  4. Backpressure: hold m_axis_tready=0 for 10 clk during test 2.
//     -> beat1 stable, s_axis_tready=0 throughout, no byte lost or duplicated.
//  5. Malformed read: 0xA1,0x02,0x33,0x44(last) -> err_fmt pulse, all bytes consumed, no beat.
//     Next write packet is packed correctly.
//  6. Assert resetn=0 after 2 payload bytes of a write -> all outputs 0 asynchronously.
//     After release, a fresh 0x50 (last) gives a null beat: tkeep=0000, tuser=50, tlast=1.

Source files
------------

// File: rtl/axis_iic_cmd_packer.sv
// Packs byte-wide I2C command packets into N_BYTES-wide AXI-Stream beats.
// The header byte rides in tuser; payload lanes are marked contiguously in tkeep.
module axis_iic_cmd_packer #(
    parameter int N_BYTES = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [N_BYTES*8-1:0] m_axis_tdata,
    output logic [N_BYTES-1:0]   m_axis_tkeep,
    output logic [7:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 err_fmt
);

    localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [2:0] {
        HDR_ST,
        WR_ST,
        RDLEN_ST,
        OUT_ST,
        DROP_ST
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s_acc;
    logic          len_ok;

    assign s_acc  = s_axis_tvalid & s_axis_tready;
    assign len_ok = (s_axis_tdata != 8'd0) && (32'(s_axis_tdata) <= 32'(N_BYTES));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= HDR_ST;
            cnt           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b0;
            err_fmt       <= 1'b0;
        end else begin
            err_fmt <= 1'b0;
            case (state)
                HDR_ST: begin
                    s_axis_tready <= 1'b1;
                    if (s_acc) begin
                        m_axis_tuser <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            if (s_axis_tdata[0]) begin
                                err_fmt <= 1'b1;
                            end else begin
                                // address probe: empty beat carrying only the header
                                m_axis_tkeep  <= '0;
                                m_axis_tlast  <= 1'b1;
                                m_axis_tvalid <= 1'b1;
                                s_axis_tready <= 1'b0;
                                state         <= OUT_ST;
                            end
                        end else begin
                            state <= s_axis_tdata[0] ? RDLEN_ST : WR_ST;
                        end
                    end
                end
                WR_ST: begin
                    s_axis_tready <= 1'b1;
                    if (s_acc) begin
                        for (int i = 0; i < N_BYTES; i++) begin
                            if (cnt == CW'(i)) begin
                                m_axis_tdata[8*i +: 8] <= s_axis_tdata;
                                m_axis_tkeep[i]        <= 1'b1;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        if (s_axis_tlast || (cnt == CW'(N_BYTES - 1))) begin
                            m_axis_tlast  <= s_axis_tlast;
                            m_axis_tvalid <= 1'b1;
                            s_axis_tready <= 1'b0;
                            state         <= OUT_ST;
                        end
                    end
                end
                RDLEN_ST: begin
                    s_axis_tready <= 1'b1;
                    if (s_acc) begin
                        if (!s_axis_tlast) begin
                            err_fmt <= 1'b1;
                            state   <= DROP_ST;
                        end else if (len_ok) begin
                            m_axis_tdata  <= {{(N_BYTES*8-8){1'b0}}, s_axis_tdata};
                            m_axis_tkeep  <= N_BYTES'(1);
                            m_axis_tlast  <= 1'b1;
                            m_axis_tvalid <= 1'b1;
                            s_axis_tready <= 1'b0;
                            state         <= OUT_ST;
                        end else begin
                            err_fmt <= 1'b1;
                            state   <= HDR_ST;
                        end
                    end
                end
                OUT_ST: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tdata  <= '0;
                        m_axis_tkeep  <= '0;
                        m_axis_tlast  <= 1'b0;
                        cnt           <= '0;
                        s_axis_tready <= 1'b1;
                        // tuser is kept so a continuation beat reuses the same header
                        state         <= m_axis_tlast ? HDR_ST : WR_ST;
                    end
                end
                DROP_ST: begin
                    s_axis_tready <= 1'b1;
                    if (s_acc && s_axis_tlast) begin
                        state <= HDR_ST;
                    end
                end
                default: begin
                    s_axis_tready <= 1'b1;
                    state         <= HDR_ST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_iic_cmd_packer.sv
// Directed bench for axis_iic_cmd_packer with N_BYTES=4; expected beats are queued
// when a packet is sent and compared by a monitor as beats are handed off.
module tb_axis_iic_cmd_packer;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [7:0]      s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            s_axis_tlast = 1'b0;
    logic [N*8-1:0]  m_axis_tdata;
    logic [N-1:0]    m_axis_tkeep;
    logic [7:0]      m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic            err_fmt;

    axis_iic_cmd_packer #(.N_BYTES(N)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .err_fmt       (err_fmt)
    );

    always #5 clk = ~clk;

    typedef logic [44:0] beat_t;  // {tdata, tkeep, tuser, tlast}
    beat_t exp_q[$];
    beat_t got_beat;
    beat_t exp_beat;
    beat_t cap_beat;
    int    errors  = 0;
    int    checks  = 0;
    int    err_cnt = 0;

    function automatic beat_t mk(logic [31:0] d, logic [3:0] k, logic [7:0] u, logic l);
        return {d, k, u, l};
    endfunction

    // monitor: counts err_fmt pulses and scores every handed-off beat
    always @(negedge clk) begin
        if (err_fmt) err_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
            got_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_beat got=%h", got_beat);
            end
            if (exp_q.size() != 0) begin
                exp_beat = exp_q.pop_front();
                checks++;
                assert (got_beat === exp_beat)
                else begin
                    errors++;
                    $error("FAIL beat got=%h exp=%h", got_beat, exp_beat);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        logic rdy;
        int   n;
        s_axis_tdata  = b;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        check("send_accept", 64'(rdy), 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
        check({tag, "_tkeep"},  64'(m_axis_tkeep),  64'd0);
        check({tag, "_tuser"},  64'(m_axis_tuser),  64'd0);
        check({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
        check({tag, "_sready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_err"},    64'(err_fmt),       64'd0);
    endtask

    initial begin
        int  e0;
        int  n;
        logic stable;
        logic rdy_seen;

        #2 resetn = 1'b0;
        #10;
        check_outputs_zero("rst");
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // write with two payload bytes; beat must appear right after the last byte
        exp_q.push_back(mk(32'h0000_2211, 4'b0011, 8'hA0, 1'b1));
        send(8'hA0, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
        wait_drain();

        // valid read
        exp_q.push_back(mk(32'h0000_0003, 4'b0001, 8'hA1, 1'b1));
        send(8'hA1, 1'b0);
        send(8'h03, 1'b1);
        wait_drain();

        // read length 0, read length N+1, and read header with tlast
        e0 = err_cnt;
        send(8'hA1, 1'b0);
        send(8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("err_len0", 64'(err_cnt), 64'(e0 + 1));
        e0 = err_cnt;
        send(8'hA1, 1'b0);
        send(8'h05, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("err_len5", 64'(err_cnt), 64'(e0 + 1));
        e0 = err_cnt;
        send(8'hA1, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("err_rd_probe", 64'(err_cnt), 64'(e0 + 1));
        wait_drain();

        // five payload bytes with 10 cycles of downstream backpressure on beat 1
        m_axis_tready = 1'b0;
        exp_q.push_back(mk(32'h0403_0201, 4'b1111, 8'hA0, 1'b0));
        exp_q.push_back(mk(32'h0000_0005, 4'b0001, 8'hA0, 1'b1));
        fork
            begin
                send(8'hA0, 1'b0);
                for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
            end
            begin
                n = 0;
                while (!m_axis_tvalid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_beat_seen", 64'(m_axis_tvalid), 64'd1);
                cap_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
                stable   = 1'b1;
                rdy_seen = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== cap_beat) stable = 1'b0;
                    if (!m_axis_tvalid) stable = 1'b0;
                    if (s_axis_tready) rdy_seen = 1'b1;
                end
                check("bp_stable", 64'(stable), 64'd1);
                check("bp_sready_low", 64'(rdy_seen), 64'd0);
                @(posedge clk);
                #1 m_axis_tready = 1'b1;
            end
        join
        wait_drain();

        // malformed read is dropped whole, then an exactly-full write
        e0 = err_cnt;
        send(8'hA1, 1'b0);
        send(8'h02, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("err_malformed", 64'(err_cnt), 64'(e0 + 1));
        exp_q.push_back(mk(32'hDDCC_BBAA, 4'b1111, 8'hB0, 1'b1));
        send(8'hB0, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b1);
        wait_drain();

        // reset in the middle of a write packet
        send(8'hA0, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        #3 resetn = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(32'h0, 4'b0000, 8'h50, 1'b1));
        send(8'h50, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
